// File: rtl/hdmux4_rr_sel_ctrl.sv
// hdmux4_rr_sel_ctrl
// Round-robin sequencer that owns the SL0/SL1 select pair of a 4:1 inverting
// mux cell and hands the mux to one of four requesters at a time. The select
// only moves while no grant is active. A settle window follows each select
// change, so an owner never sees the select lines transition.
module hdmux4_rr_sel_ctrl #(
    parameter int SETTLE_CYC = 1,  // cycles GNT stays low after a select change (1..15)
    parameter int MAX_HOLD   = 8,  // max grant length in cycles; 0 = unlimited
    parameter int CNT_W      = 8   // hold counter width
) (
    input  logic       CK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic [3:0] REL,
    output logic       SL0,
    output logic       SL1,
    output logic [3:0] GNT,
    output logic       BUSY,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_OWN    = 2'b10
    } state_e;

    // Terminal counts, pre-sized to the counters they are compared against.
    localparam logic [3:0]       SETTLE_LAST  = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT     = {CNT_W{1'b1}};
    localparam logic             HOLD_LIMITED = (MAX_HOLD != 0);

    // Round-robin pick: bit 2 = a winner exists, bits 1:0 = winner index.
    // The search starts just after the last owner and wraps. Iterating from
    // the lowest-priority offset upward lets the closest requester win.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot grant vector for a mux input index.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       sl_q, sl_d;          // current select, also the current winner W
    logic [1:0]       last_q, last_d;      // last completed owner
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [2:0]       pick_s;
    logic             rel_own_s;
    logic             req_drop_s;
    logic             hold_lim_s;

    // Next-state and output decode for the IDLE / SETTLE / OWN sequence.
    always_comb begin
        state_d      = state_q;
        sl_d         = sl_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        timeout_d    = 1'b0;
        settle_cnt_d = settle_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        pick_s     = rr_pick(REQ, last_q);
        rel_own_s  = REL[sl_q];
        req_drop_s = ~REQ[sl_q];
        hold_lim_s = HOLD_LIMITED && (hold_cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE: begin
                gnt_d = 4'b0000;
                if (pick_s[2]) begin
                    // Select moves only here, while nobody holds a grant.
                    sl_d         = pick_s[1:0];
                    settle_cnt_d = 4'd0;
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                gnt_d = 4'b0000;
                if (req_drop_s) begin
                    // Winner withdrew before being granted; LAST is kept.
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    gnt_d      = onehot4(sl_q);
                    hold_cnt_d = {CNT_W{1'b0}};
                    state_d    = ST_OWN;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end

            ST_OWN: begin
                if (rel_own_s || req_drop_s || hold_lim_s) begin
                    gnt_d     = 4'b0000;
                    last_d    = sl_q;
                    state_d   = ST_IDLE;
                    // Timeout is flagged only when the limit alone ended the grant.
                    timeout_d = hold_lim_s && !rel_own_s && !req_drop_s;
                end else begin
                    gnt_d = onehot4(sl_q);
                    if (hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_d = hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                end
            end

            default: begin
                gnt_d   = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output update; RST returns everything to idle with index 0 next.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            sl_q         <= 2'b00;
            last_q       <= 2'b11;
            gnt_q        <= 4'b0000;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            settle_cnt_q <= 4'd0;
            hold_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            sl_q         <= sl_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            settle_cnt_q <= settle_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign SL0     = sl_q[0];
    assign SL1     = sl_q[1];
    assign GNT     = gnt_q;
    assign BUSY    = busy_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_hdmux4_rr_sel_ctrl.sv
// Directed testbench for hdmux4_rr_sel_ctrl with default parameters
// (SETTLE_CYC=1, MAX_HOLD=8). Inputs change 1 ns after each rising edge and
// outputs are checked at that same point; a negedge monitor checks the
// grant/select invariants.
module tb_hdmux4_rr_sel_ctrl;

    logic       CK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] REL;
    logic       SL0;
    logic       SL1;
    logic [3:0] GNT;
    logic       BUSY;
    logic       TIMEOUT;

    int n_cmp = 0;
    int n_err = 0;

    hdmux4_rr_sel_ctrl dut (
        .CK      (CK),
        .RST     (RST),
        .REQ     (REQ),
        .REL     (REL),
        .SL0     (SL0),
        .SL1     (SL1),
        .GNT     (GNT),
        .BUSY    (BUSY),
        .TIMEOUT (TIMEOUT)
    );

    // 10 ns clock.
    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = 4'b0000;
        REL = 4'b0000;
        step();
        step();
        RST = 1'b0;
    endtask

    // Invariants: one-hot grant matching the select, select stable under grant.
    logic [1:0] sl_prev = 2'b00;
    always @(negedge CK) begin
        if (GNT != 4'b0000) begin
            check_val("gnt_onehot", {31'd0, $onehot(GNT)}, 32'd1);
            check_val("gnt_at_sel", {31'd0, GNT[{SL1, SL0}]}, 32'd1);
            check_val("sl_stable", {30'd0, SL1, SL0}, {30'd0, sl_prev});
        end
        sl_prev <= {SL1, SL0};
    end

    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;

    initial begin
        RST = 1'b1;
        REQ = 4'b0000;
        REL = 4'b0000;

        // Reset state
        do_reset();
        check_val("rst_sl",   {30'd0, SL1, SL0}, 32'd0);
        check_val("rst_gnt",  {28'd0, GNT}, 32'd0);
        check_val("rst_busy", {31'd0, BUSY}, 32'd0);
        check_val("rst_to",   {31'd0, TIMEOUT}, 32'd0);

        // Test 1: single requester, released by REL pulse
        REQ = 4'b0001;
        step();
        check_val("t1_sl",     {30'd0, SL1, SL0}, 32'd0);
        check_val("t1_gnt_lo", {28'd0, GNT}, 32'd0);
        check_val("t1_busy",   {31'd0, BUSY}, 32'd1);
        step();
        check_val("t1_gnt",    {28'd0, GNT}, 32'h1);
        step();
        REL = 4'b0001;
        step();
        REL = 4'b0000;
        REQ = 4'b0000;
        check_val("t1_rel_gnt",  {28'd0, GNT}, 32'd0);
        check_val("t1_rel_busy", {31'd0, BUSY}, 32'd0);
        check_val("t1_rel_to",   {31'd0, TIMEOUT}, 32'd0);

        // Test 2: all requesting, timeouts rotate 0,1,2,3,0
        do_reset();
        REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << order[g];
            step();
            check_val("t2_sl",     {30'd0, SL1, SL0}, order[g]);
            check_val("t2_gap",    {28'd0, GNT}, 32'd0);
            check_val("t2_to_lo",  {31'd0, TIMEOUT}, 32'd0);
            step();
            check_val("t2_gnt",    {28'd0, GNT}, {28'd0, exp_g});
            repeat (7) step();
            check_val("t2_gnt_8",  {28'd0, GNT}, {28'd0, exp_g});
            step();
            check_val("t2_end",    {28'd0, GNT}, 32'd0);
            check_val("t2_to",     {31'd0, TIMEOUT}, 32'd1);
        end
        step();
        check_val("t2_to_pulse", {31'd0, TIMEOUT}, 32'd0);
        REQ = 4'b0000;
        step();

        // Test 3: owner 2, then 3 and 0 rise -> 3 then 0 (wrap)
        do_reset();
        REQ = 4'b0100;
        step();
        step();
        check_val("t3_gnt2", {28'd0, GNT}, 32'h4);
        REQ = 4'b1101;
        step();
        check_val("t3_nopre", {28'd0, GNT}, 32'h4);
        REL = 4'b0100;
        step();
        REL = 4'b0000;
        REQ = 4'b1001;
        check_val("t3_rel2", {28'd0, GNT}, 32'd0);
        step();
        check_val("t3_sl3", {30'd0, SL1, SL0}, 32'd3);
        step();
        check_val("t3_gnt3", {28'd0, GNT}, 32'h8);
        REQ = 4'b0001;
        step();
        check_val("t3_drop3", {28'd0, GNT}, 32'd0);
        check_val("t3_drop_to", {31'd0, TIMEOUT}, 32'd0);
        step();
        check_val("t3_sl0", {30'd0, SL1, SL0}, 32'd0);
        step();
        check_val("t3_gnt0", {28'd0, GNT}, 32'h1);
        REQ = 4'b0000;
        step();

        // Test 4: abort during SETTLE keeps LAST (=0), so 1 wins over 0
        REQ = 4'b0010;
        step();
        check_val("t4_sl1", {30'd0, SL1, SL0}, 32'd1);
        REQ = 4'b0000;
        step();
        check_val("t4_abort_gnt",  {28'd0, GNT}, 32'd0);
        check_val("t4_abort_busy", {31'd0, BUSY}, 32'd0);
        REQ = 4'b0011;
        step();
        check_val("t4_sl_again", {30'd0, SL1, SL0}, 32'd1);
        step();
        check_val("t4_gnt1", {28'd0, GNT}, 32'h2);
        REL = 4'b0010;
        step();
        REL = 4'b0000;
        REQ = 4'b0000;
        step();

        // Test 5: reset during OWN with GNT=0100
        REQ = 4'b0100;
        step();
        step();
        check_val("t5_gnt2", {28'd0, GNT}, 32'h4);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_val("t5_rst_gnt",  {28'd0, GNT}, 32'd0);
        check_val("t5_rst_sl",   {30'd0, SL1, SL0}, 32'd0);
        check_val("t5_rst_busy", {31'd0, BUSY}, 32'd0);
        REQ = 4'b0101;
        step();
        check_val("t5_sl0", {30'd0, SL1, SL0}, 32'd0);
        step();
        check_val("t5_gnt0", {28'd0, GNT}, 32'h1);
        REQ = 4'b0000;
        step();

        // Test 6: foreign REL ignored; REL coinciding with limit gives no TIMEOUT
        REQ = 4'b1000;
        step();
        step();
        check_val("t6_gnt3", {28'd0, GNT}, 32'h8);
        REL = 4'b0001;
        step();
        REL = 4'b0000;
        check_val("t6_foreign_rel", {28'd0, GNT}, 32'h8);
        repeat (6) step();
        check_val("t6_pre_limit", {28'd0, GNT}, 32'h8);
        REL = 4'b1000;
        step();
        REL = 4'b0000;
        REQ = 4'b0000;
        check_val("t6_coinc_gnt", {28'd0, GNT}, 32'd0);
        check_val("t6_coinc_to",  {31'd0, TIMEOUT}, 32'd0);
        check_val("t6_coinc_busy", {31'd0, BUSY}, 32'd0);
        step();
        check_val("t6_idle_to", {31'd0, TIMEOUT}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
